// File: rtl/music_tone.sv
// Buzzer tone generator: latches a note code on each synchronized beat rise,
// holds a silent articulation gap, then drives a square wave at the note's pitch.
`timescale 1ns/1ps

module music_tone #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned GAP_CYCLES = 2500000
) (
    input  logic       in_clk,
    input  logic       rst,
    input  logic       beat,
    input  logic [4:0] note,
    output logic       beep,
    output logic [4:0] note_q,
    output logic       playing
);

    localparam int unsigned CW = 22;
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GAP, PLAY} state_t;

    function automatic int unsigned tone_hz(input int unsigned code);
        case (code)
            1:  return 131;  2:  return 147;  3:  return 165;  4:  return 175;
            5:  return 196;  6:  return 220;  7:  return 247;
            8:  return 262;  9:  return 294;  10: return 330;  11: return 349;
            12: return 392;  13: return 440;  14: return 494;
            15: return 523;  16: return 587;  17: return 659;  18: return 698;
            19: return 784;  20: return 880;  21: return 988;
            default: return 0;
        endcase
    endfunction

    // Entries are counter-width: the lowest notes need 18 bits at 50 MHz.
    function automatic logic [32*CW-1:0] build_div();
        logic [32*CW-1:0] t;
        t = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (tone_hz(i) != 0)
                t[i*CW +: CW] = CW'(CLK_FREQ / (2 * tone_hz(i)));
        end
        return t;
    endfunction

    localparam logic [32*CW-1:0] DIV_TABLE = build_div();

    function automatic logic is_pitched(input logic [4:0] c);
        return (c != 5'd0) && (c <= 5'd21);
    endfunction

    state_t          state, state_d;
    logic            s1, s2, s3;
    logic [1:0]      settle;
    logic            armed;
    logic            rise;
    logic [CW-1:0]   gap_cnt, gap_d;
    logic [CW-1:0]   hp_cnt, hp_d;
    logic [CW-1:0]   div;
    logic            beep_d;
    logic [4:0]      note_q_d;
    logic            playing_d;

    // A rise is only accepted once s2 has been seen low after reset, so a beat
    // already high at release does not count as an edge.
    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            s1 <= beat;
            s2 <= s1;
            s3 <= s2;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            else if (!s2)
                armed <= 1'b1;
        end
    end

    assign rise = s2 & ~s3 & armed;
    assign div  = DIV_TABLE[note_q*CW +: CW];

    always_comb begin
        state_d  = state;
        gap_d    = gap_cnt;
        hp_d     = hp_cnt;
        beep_d   = beep;
        note_q_d = note_q;
        if (rise) begin
            state_d  = GAP;
            note_q_d = note;
            gap_d    = '0;
            hp_d     = '0;
            beep_d   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gap_d  = '0;
                    hp_d   = '0;
                    beep_d = 1'b0;
                end
                GAP: begin
                    beep_d = 1'b0;
                    hp_d   = '0;
                    if (gap_cnt == GAP_LAST) begin
                        state_d = PLAY;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_cnt + 1'b1;
                    end
                end
                PLAY: begin
                    gap_d = '0;
                    if (!is_pitched(note_q)) begin
                        hp_d   = '0;
                        beep_d = 1'b0;
                    end else if (hp_cnt == div - 1'b1) begin
                        hp_d   = '0;
                        beep_d = ~beep;
                    end else begin
                        hp_d = hp_cnt + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gap_d   = '0;
                    hp_d    = '0;
                    beep_d  = 1'b0;
                end
            endcase
        end
        playing_d = (state_d == PLAY) && is_pitched(note_q_d);
    end

    always_ff @(posedge in_clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            hp_cnt  <= '0;
            beep    <= 1'b0;
            note_q  <= '0;
            playing <= 1'b0;
        end else begin
            state   <= state_d;
            gap_cnt <= gap_d;
            hp_cnt  <= hp_d;
            beep    <= beep_d;
            note_q  <= note_q_d;
            playing <= playing_d;
        end
    end

endmodule

// File: tb/tb_music_tone.sv
// Bench for music_tone: expected beep edges are queued per note segment and
// matched against every observed beep transition.
`timescale 1ns/1ps

module tb_music_tone;

    localparam int unsigned CLK_FREQ = 200000;
    localparam int unsigned GAP      = 100;

    logic       in_clk = 1'b0;
    logic       rst;
    logic       beat;
    logic [4:0] note;
    logic       beep;
    logic [4:0] note_q;
    logic       playing;

    music_tone #(
        .CLK_FREQ   (CLK_FREQ),
        .GAP_CYCLES (GAP)
    ) dut (
        .in_clk  (in_clk),
        .rst     (rst),
        .beat    (beat),
        .note    (note),
        .beep    (beep),
        .note_q  (note_q),
        .playing (playing)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    typedef struct {
        int   cycle;
        logic val;
    } ev_t;

    ev_t  sb[$];
    logic beep_prev = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int expected_div(input int code);
        int f;
        case (code)
            1: f = 131;  2: f = 147;  3: f = 165;  4: f = 175;  5: f = 196;
            6: f = 220;  7: f = 247;  8: f = 262;  9: f = 294;  10: f = 330;
            11: f = 349; 12: f = 392; 13: f = 440; 14: f = 494; 15: f = 523;
            16: f = 587; 17: f = 659; 18: f = 698; 19: f = 784; 20: f = 880;
            21: f = 988;
            default: f = 0;
        endcase
        return (f == 0) ? 0 : int'(CLK_FREQ) / (2 * f);
    endfunction

    // Every beep transition must match the head of the scoreboard.
    always @(negedge in_clk) begin
        if (beep !== beep_prev) begin
            if (sb.size() == 0) begin
                check("beep_unexpected", int'(beep), int'(beep_prev));
            end else begin
                ev_t e;
                e = sb.pop_front();
                check("beep_cycle", cyc, e.cycle);
                check("beep_value", int'(beep), int'(e.val));
            end
        end
        beep_prev = beep;
    end

    // One note segment: beat rises now, next rise (or reset) comes len cycles later.
    task automatic seg(input int n, input int len, input bit end_rst);
        int base, lat, d, t, cnt;
        base = cyc;
        lat  = base + 3;
        note = 5'(n);
        beat = 1'b1;
        d    = expected_div(n);
        cnt  = 0;
        if (d > 0) begin
            t = lat + int'(GAP) + d;
            while (end_rst ? (t <= base + len) : (t < base + len + 3)) begin
                sb.push_back(ev_t'{t, (cnt % 2 == 0)});
                cnt++;
                t += d;
            end
            if (cnt % 2 == 1)
                sb.push_back(ev_t'{end_rst ? base + len + 1 : base + len + 3, 1'b0});
        end
        repeat (4) @(negedge in_clk);
        check("note_q_latch", note_q, n);
        check("gap_beep", beep, 0);
        check("gap_playing", playing, 0);
        beat = 1'b0;
        note = 5'($urandom);
        if (len > int'(GAP) + 10) begin
            repeat (GAP - 2) @(negedge in_clk);
            check("playing_before_gap_end", playing, 0);
            @(negedge in_clk);
            check("playing_at_gap_end", playing, (n >= 1 && n <= 21) ? 1 : 0);
            note = 5'($urandom);
            repeat (len - int'(GAP) - 3) @(negedge in_clk);
        end else begin
            repeat (len - 4) @(negedge in_clk);
        end
        check("note_q_hold", note_q, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        beat = 1'b0;
        note = 5'd0;
        repeat (3) @(negedge in_clk);
        check("reset_beep", beep, 0);
        check("reset_note_q", note_q, 0);
        check("reset_playing", playing, 0);
        #2 rst = 1'b1;
        repeat (5) @(negedge in_clk);

        seg(13, 831, 1'b0);
        seg(0, 400, 1'b0);
        seg(25, 400, 1'b0);
        seg(1, 1000, 1'b0);
        seg(1, 1000, 1'b0);
        seg(5, 50, 1'b0);
        seg(8, 900, 1'b0);
        seg(21, 450, 1'b1);

        #2 rst = 1'b0;
        #1;
        check("async_rst_beep", beep, 0);
        check("async_rst_note_q", note_q, 0);
        check("async_rst_playing", playing, 0);
        repeat (3) @(negedge in_clk);
        #2 rst = 1'b1;
        repeat (200) @(negedge in_clk);
        check("idle_beep", beep, 0);
        check("idle_playing", playing, 0);
        check("idle_note_q", note_q, 0);

        #2 rst = 1'b0;
        beat = 1'b1;
        note = 5'd13;
        repeat (3) @(negedge in_clk);
        #2 rst = 1'b1;
        repeat (30) @(negedge in_clk);
        check("beat_high_at_release_note_q", note_q, 0);
        check("beat_high_at_release_playing", playing, 0);
        beat = 1'b0;
        repeat (5) @(negedge in_clk);

        seg(15, 600, 1'b0);
        seg(0, 20, 1'b0);

        repeat (20) @(negedge in_clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
